// File: rtl/uart_rx_word_fifo_if.sv
// Bundle of the byte-receiver, consumer and status signals of uart_rx_word_fifo.
// master: the side feeding bytes and popping words; slave: the FIFO block itself.
interface uart_rx_word_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [7:0]          rdata;
    logic                rdata_ready;
    logic                ferr;
    logic                pop;
    logic                flush;
    logic                clr_err;
    logic [31:0]         dout;
    logic                dout_valid;
    logic [DEPTH_LOG2:0] count;
    logic [1:0]          byte_idx;
    logic                overflow;
    logic                frame_err;

    modport master (
        output rdata, rdata_ready, ferr, pop, flush, clr_err,
        input  dout, dout_valid, count, byte_idx, overflow, frame_err
    );

    modport slave (
        input  rdata, rdata_ready, ferr, pop, flush, clr_err,
        output dout, dout_valid, count, byte_idx, overflow, frame_err
    );
endinterface

// File: rtl/uart_rx_word_fifo.sv
// UART receive word packer + show-ahead word FIFO.
// Bytes are taken on the rising edge of rdata_ready, packed four to a 32-bit
// word and queued. Sticky overflow / framing-error flags.
// Optional: define RX_BIG_ENDIAN_EN to place the first byte in the MSB.
module uart_rx_word_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input logic               clk,
    input logic               rstn,
    uart_rx_word_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

    logic                  rdy_q;
    logic [31:0]           part;
    logic [1:0]            bidx;
    logic [DEPTH_LOG2-1:0] rptr;
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2:0]   cnt;
    logic                  ovf;
    logic                  ferr_q;
    logic [31:0]           mem [DEPTH];

    logic        take;
    logic [1:0]  lane;
    logic [31:0] word_in;
    logic        full;
    logic        pop_do;
    logic        word_done;
    logic        push_do;
    logic        ovf_set;

    assign take = bus.rdata_ready & ~rdy_q;

`ifdef RX_BIG_ENDIAN_EN
    // byte k lands in lane 3-k, i.e. the bitwise inverse of k
    assign lane = ~bidx;
`else
    assign lane = bidx;
`endif

    // Partial word with the incoming byte merged into its lane
    always_comb begin
        word_in = part;
        word_in[{lane, 3'b000} +: 8] = bus.rdata;
    end

    assign full      = (cnt == DEPTH_CNT);
    assign pop_do    = bus.pop & (cnt != '0);
    assign word_done = take & (bidx == 2'd3) & ~bus.flush;
    // A full FIFO still accepts a word when the head leaves in the same cycle
    assign push_do   = word_done & (~full | pop_do);
    assign ovf_set   = word_done & full & ~pop_do;

    // Edge detect and byte assembly; flush discards the partial word
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdy_q <= 1'b0;
            part  <= '0;
            bidx  <= '0;
        end else begin
            rdy_q <= bus.rdata_ready;
            if (bus.flush) begin
                part <= '0;
                bidx <= '0;
            end else if (take) begin
                part <= (bidx == 2'd3) ? 32'd0 : word_in;
                bidx <= bidx + 2'd1;
            end
        end
    end

    // Read/write pointers and occupancy
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
        end else if (bus.flush) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
        end else begin
            if (push_do) wptr <= wptr + 1'b1;
            if (pop_do)  rptr <= rptr + 1'b1;
            if (push_do && !pop_do)      cnt <= cnt + 1'b1;
            else if (pop_do && !push_do) cnt <= cnt - 1'b1;
        end
    end

    // Word storage; contents are only observed through valid entries
    always_ff @(posedge clk) begin
        if (push_do) mem[wptr] <= word_in;
    end

    // Sticky flags: a set condition beats a simultaneous clear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf    <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            if (bus.clr_err) begin
                ovf    <= 1'b0;
                ferr_q <= 1'b0;
            end
            if (ovf_set)          ovf    <= 1'b1;
            if (take && bus.ferr) ferr_q <= 1'b1;
        end
    end

    assign bus.dout       = (cnt != '0) ? mem[rptr] : 32'd0;
    assign bus.dout_valid = (cnt != '0);
    assign bus.count      = cnt;
    assign bus.byte_idx   = bidx;
    assign bus.overflow   = ovf;
    assign bus.frame_err  = ferr_q;
endmodule

// File: tb/tb_uart_rx_word_fifo.sv
// Scoreboard bench for uart_rx_word_fifo: byte-stream reference model feeds an
// expected-word queue; a negedge monitor checks every popped word.
module tb_uart_rx_word_fifo;
    localparam int DL2   = 4;
    localparam int DEPTH = 1 << DL2;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    uart_rx_word_fifo_if #(.DEPTH_LOG2(DL2)) u_if ();

    uart_rx_word_fifo #(.DEPTH_LOG2(DL2)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (u_if.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]  pb[$];
    logic [31:0] exp_q[$];
    logic        exp_ovf;
    logic        exp_ferr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mkword(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3);
`ifdef RX_BIG_ENDIAN_EN
        return {b0, b1, b2, b3};
`else
        return {b3, b2, b1, b0};
`endif
    endfunction

    task automatic model_clear_all();
        pb.delete();
        exp_q.delete();
        exp_ovf  = 1'b0;
        exp_ferr = 1'b0;
    endtask

    // Reference: one byte taken this cycle, with pop p and clr_err cl alongside
    task automatic model_byte(input logic [7:0] b, input logic e, input logic p, input logic cl);
        int occ;
        if (cl) begin
            exp_ovf  = 1'b0;
            exp_ferr = 1'b0;
        end
        if (e) exp_ferr = 1'b1;
        pb.push_back(b);
        if (pb.size() == 4) begin
            occ = exp_q.size();
            if (p && occ > 0) occ--;
            if (occ < DEPTH) exp_q.push_back(mkword(pb[0], pb[1], pb[2], pb[3]));
            else             exp_ovf = 1'b1;
            pb.delete();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_count"}, 32'(u_if.count), 32'(exp_q.size()));
        chk({tag, "_byte_idx"}, 32'(u_if.byte_idx), 32'(pb.size()));
        chk({tag, "_valid"}, 32'(u_if.dout_valid), 32'(exp_q.size() > 0));
        chk({tag, "_overflow"}, 32'(u_if.overflow), 32'(exp_ovf));
        chk({tag, "_frame_err"}, 32'(u_if.frame_err), 32'(exp_ferr));
        if (exp_q.size() > 0) chk({tag, "_head"}, u_if.dout, exp_q[0]);
    endtask

    task automatic send_byte(input string tag, input logic [7:0] b, input logic e,
                             input logic p, input logic cl);
        u_if.rdata       = b;
        u_if.rdata_ready = 1'b1;
        u_if.ferr        = e;
        u_if.pop         = p;
        u_if.clr_err     = cl;
        model_byte(b, e, p, cl);
        tick();
        u_if.rdata_ready = 1'b0;
        u_if.ferr        = 1'b0;
        u_if.pop         = 1'b0;
        u_if.clr_err     = 1'b0;
        chk_state(tag);
        tick();
    endtask

    task automatic do_pop();
        u_if.pop = 1'b1;
        tick();
        u_if.pop = 1'b0;
    endtask

    task automatic do_clr();
        u_if.clr_err = 1'b1;
        exp_ovf  = 1'b0;
        exp_ferr = 1'b0;
        tick();
        u_if.clr_err = 1'b0;
    endtask

    task automatic do_flush();
        u_if.flush = 1'b1;
        pb.delete();
        exp_q.delete();
        tick();
        u_if.flush = 1'b0;
    endtask

    // Monitor: every accepted pop must present the oldest expected word
    always @(negedge clk) begin
        if (rstn && u_if.pop && u_if.dout_valid && !u_if.flush) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL pop_unexpected actual=%h required=none", u_if.dout);
            end else begin
                chk("pop_data", u_if.dout, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [7:0] rb;
        int r;
        u_if.rdata = 8'h00; u_if.rdata_ready = 1'b0; u_if.ferr = 1'b0;
        u_if.pop = 1'b0; u_if.flush = 1'b0; u_if.clr_err = 1'b0;
        model_clear_all();
        rstn = 1'b0;
        #3;
        chk("rst_dout", u_if.dout, 32'h0);
        chk_state("rst");
        tick(); tick();
        rstn = 1'b1;
        tick();
        chk_state("idle");

        // Directed word
        send_byte("b11", 8'h11, 1'b0, 1'b0, 1'b0);
        send_byte("b22", 8'h22, 1'b0, 1'b0, 1'b0);
        send_byte("b33", 8'h33, 1'b0, 1'b0, 1'b0);
        send_byte("b44", 8'h44, 1'b0, 1'b0, 1'b0);
`ifdef RX_BIG_ENDIAN_EN
        chk("word_1234", u_if.dout, 32'h11223344);
`else
        chk("word_1234", u_if.dout, 32'h44332211);
`endif
        do_pop();
        chk_state("after_pop");

        // Level held high: exactly one byte
        u_if.rdata = 8'hAA; u_if.rdata_ready = 1'b1;
        model_byte(8'hAA, 1'b0, 1'b0, 1'b0);
        repeat (10) tick();
        u_if.rdata_ready = 1'b0;
        tick();
        chk_state("held_high");
        for (int i = 0; i < 3; i++) send_byte("held_fill", 8'(8'hB0 + i), 1'b0, 1'b0, 1'b0);
        do_pop();

        // 17 words into a 16-deep FIFO
        for (int i = 0; i < 17 * 4; i++) send_byte("fill", 8'($urandom), 1'b0, 1'b0, 1'b0);
        chk_state("full");
        do_clr();
        // Push and pop in the same cycle while full
        for (int i = 0; i < 3; i++) send_byte("pp_part", 8'($urandom), 1'b0, 1'b0, 1'b0);
        send_byte("pp_push_pop", 8'hC3, 1'b0, 1'b1, 1'b0);
        repeat (DEPTH) do_pop();
        chk_state("drained");

        // Framing error handling
        send_byte("ferr_set", 8'h5A, 1'b1, 1'b0, 1'b0);
        do_clr();
        chk_state("ferr_clr");
        send_byte("ferr_clr_set", 8'h6B, 1'b1, 1'b0, 1'b1);
        send_byte("ferr_fill", 8'h7C, 1'b0, 1'b0, 1'b0);
        send_byte("ferr_fill", 8'h8D, 1'b0, 1'b0, 1'b0);
        do_pop();
        do_clr();

        // Flush discards the partial word and stored words
        for (int i = 0; i < 4; i++) send_byte("pre_flush_w", 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
        send_byte("pre_flush", 8'hE1, 1'b0, 1'b0, 1'b0);
        send_byte("pre_flush", 8'hE2, 1'b0, 1'b0, 1'b0);
        do_flush();
        chk_state("flush");
        for (int i = 0; i < 4; i++) send_byte("post_flush", 8'(8'h90 + i), 1'b0, 1'b0, 1'b0);
        do_pop();
        chk_state("post_flush_pop");

        // Randomized traffic: fill-heavy then drain-heavy
        for (int i = 0; i < 400; i++) begin
            r  = $urandom_range(0, 9);
            rb = 8'($urandom);
            if (r < 6) begin
                send_byte("rnd", rb, ($urandom_range(0, 7) == 0),
                          (i < 200) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1),
                          ($urandom_range(0, 9) == 0));
            end else if (r < 9) begin
                if (i >= 200 || r == 8) do_pop();
                else tick();
            end else if ($urandom_range(0, 4) == 0) begin
                do_flush();
                chk_state("rnd_flush");
            end else begin
                tick();
            end
        end
        repeat (DEPTH + 1) do_pop();
        chk_state("rnd_drain");

        // Asynchronous reset mid-word with words stored
        for (int i = 0; i < 6; i++) send_byte("pre_rst", 8'($urandom), 1'b1, 1'b0, 1'b0);
        #2;
        rstn = 1'b0;
        model_clear_all();
        #1;
        chk("midrst_dout", u_if.dout, 32'h0);
        chk_state("midrst");
        tick();
        rstn = 1'b1;
        tick();
        chk_state("midrst_release");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
